wb_regfile: RTL and testbench

- Architectural register file fed by the write-back stage's WB_Data / write port.
- Provides two combinational read ports to decode.
- Contains a pending-write scoreboard: decode marks a destination busy at issue, and write-back clears it. From that scoreboard the block raises a RAW/WAW stall to the front end.

---
 rtl/wb_regfile.sv | 106 ++++++++++
 tb/tb_wb_regfile.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: register file, two combinational read ports, pending-write scoreboard raising RAW/WAW issue stall.
// Writes visible 1 cycle after the edge; define WB_BYPASS_EN for write-first bypass that releases the stall in the WB cycle.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_stall,
  input  logic            WB_En,
  input  logic [AW-1:0]   WB_Addr,
  input  logic [XLEN-1:0] WB_Data
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [XLEN-1:0] regs_q  [NREG];
  logic [XLEN-1:0] regs_d  [NREG];
  logic [0:0]      state_q [NREG];
  logic [0:0]      state_d [NREG];
  logic [NREG-1:0] busy;

  logic wb_wr;
  logic issue_fire;
  logic clr_rs1, clr_rs2, clr_rd;
  logic hz_rs1, hz_rs2, hz_rd;

  assign wb_wr      = WB_En && (WB_Addr != '0);
  assign issue_fire = issue_valid && !issue_stall && (issue_rd != '0);

  always_comb begin
    busy[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      busy[i] = (state_q[i] == PENDING);
    end
  end

`ifdef WB_BYPASS_EN
  // A register retiring this cycle is forwarded, so it no longer blocks issue.
  assign clr_rs1  = WB_En && (WB_Addr == rs1_addr);
  assign clr_rs2  = WB_En && (WB_Addr == rs2_addr);
  assign clr_rd   = WB_En && (WB_Addr == issue_rd);
  assign rs1_data = (rs1_addr == '0) ? '0 :
                    (wb_wr && (WB_Addr == rs1_addr)) ? WB_Data : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 :
                    (wb_wr && (WB_Addr == rs2_addr)) ? WB_Data : regs_q[rs2_addr];
`else
  assign clr_rs1  = 1'b0;
  assign clr_rs2  = 1'b0;
  assign clr_rd   = 1'b0;
  assign rs1_data = (rs1_addr == '0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs_q[rs2_addr];
`endif

  assign hz_rs1      = (rs1_addr != '0) && busy[rs1_addr] && !clr_rs1;
  assign hz_rs2      = (rs2_addr != '0) && busy[rs2_addr] && !clr_rs2;
  assign hz_rd       = (issue_rd != '0) && busy[issue_rd] && !clr_rd;
  assign issue_stall = issue_valid && (hz_rs1 || hz_rs2 || hz_rd);

  // Entry 0 is never updated, so it stays at its reset value of zero and IDLE.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i]  = regs_q[i];
      state_d[i] = state_q[i];
    end
    for (int i = 1; i < NREG; i++) begin
      if (wb_wr && (WB_Addr == AW'(i))) begin
        regs_d[i] = WB_Data;
      end
      case (state_q[i])
        IDLE: begin
          if (issue_fire && (issue_rd == AW'(i))) state_d[i] = PENDING;
        end
        PENDING: begin
          // A same-cycle issue to this register keeps ownership with the newer writer.
          if (!(issue_fire && (issue_rd == AW'(i))) && wb_wr && (WB_Addr == AW'(i)))
            state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i]  <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i]  <= regs_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus randomized traffic against an array-based reference model.
module tb_wb_regfile;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, issue_rd, WB_Addr;
  logic [XLEN-1:0] rs1_data, rs2_data, WB_Data;
  logic            issue_valid, issue_stall, WB_En;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_busy [NREG];

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .WB_En(WB_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data)
  );

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    rs1_addr = '0; rs2_addr = '0; issue_valid = 1'b0; issue_rd = '0;
    WB_En = 1'b0; WB_Addr = '0; WB_Data = '0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit m_retiring(input logic [AW-1:0] a);
`ifdef WB_BYPASS_EN
    return WB_En && (WB_Addr == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (m_retiring(a)) return WB_Data;
    return m_reg[a];
  endfunction

  function automatic bit m_hz(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a] && !m_retiring(a);
  endfunction

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic cyc(input string tag);
    bit exp_stall;
    @(negedge clk);
    exp_stall = issue_valid && (m_hz(rs1_addr) || m_hz(rs2_addr) || m_hz(issue_rd));
    chk({tag, ".stall"}, XLEN'(issue_stall), XLEN'(exp_stall));
    chk({tag, ".rs1"}, rs1_data, m_read(rs1_addr));
    chk({tag, ".rs2"}, rs2_data, m_read(rs2_addr));
    @(posedge clk);
    if (WB_En && WB_Addr != 0) begin
      m_reg[WB_Addr]  = WB_Data;
      m_busy[WB_Addr] = 1'b0;
    end
    if (issue_valid && !exp_stall && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_reset();
    rs1_addr = 5'd5; rs2_addr = 5'd9; issue_valid = 1'b1; issue_rd = 5'd3;
    #2;
    chk("reset.rs1", rs1_data, 32'h0);
    chk("reset.rs2", rs2_data, 32'h0);
    chk("reset.stall", XLEN'(issue_stall), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    idle_inputs();

    // Write then read back
    WB_En = 1'b1; WB_Addr = 5'd3; WB_Data = 32'hDEADBEEF;
    cyc("wr");
    idle_inputs(); rs2_addr = 5'd3; #1;
    chk("rd.x3", rs2_data, 32'hDEADBEEF);
    cyc("rd");

    // x0 stays zero and never becomes busy
    WB_En = 1'b1; WB_Addr = 5'd0; WB_Data = 32'hFFFFFFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    cyc("x0w");
    idle_inputs(); issue_valid = 1'b1; #1;
    chk("x0.rd", rs1_data, 32'h0);
    chk("x0.nostall", XLEN'(issue_stall), 32'h0);
    cyc("x0r");

    // Mid-cycle reset discards a pending entry
    idle_inputs(); WB_En = 1'b1; WB_Addr = 5'd5; WB_Data = 32'h1234;
    cyc("pre5w");
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd5;
    cyc("pre5i");
    idle_inputs(); issue_valid = 1'b1; rs1_addr = 5'd5; #1;
    chk("pre5.stall", XLEN'(issue_stall), 32'h1);
    chk("pre5.rd", rs1_data, 32'h1234);
    rst_n = 1'b0; #1;
    chk("arst.rs1", rs1_data, 32'h0);
    chk("arst.stall", XLEN'(issue_stall), 32'h0);
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("post.stall", XLEN'(issue_stall), 32'h0);
    cyc("post");

    // RAW stall released by write-back
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd7;
    cyc("raw.iss");
    idle_inputs(); issue_valid = 1'b1; rs1_addr = 5'd7; #1;
    chk("raw.stall", XLEN'(issue_stall), 32'h1);
    cyc("raw.h1");
    cyc("raw.h2");
    WB_En = 1'b1; WB_Addr = 5'd7; WB_Data = 32'h55; #1;
`ifdef WB_BYPASS_EN
    chk("raw.wbstall", XLEN'(issue_stall), 32'h0);
    chk("raw.wbdata", rs1_data, 32'h55);
    cyc("raw.wb");
`else
    chk("raw.wbstall", XLEN'(issue_stall), 32'h1);
    cyc("raw.wb");
    WB_En = 1'b0; #1;
    chk("raw.late.stall", XLEN'(issue_stall), 32'h0);
    chk("raw.late.data", rs1_data, 32'h55);
    cyc("raw.late");
`endif

    // Same-cycle set and clear: set wins
`ifdef WB_BYPASS_EN
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd9;
    cyc("sc.pre");
`endif
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd9;
    WB_En = 1'b1; WB_Addr = 5'd9; WB_Data = 32'h99; #1;
    chk("sc.accept", XLEN'(issue_stall), 32'h0);
    cyc("sc");
    idle_inputs(); issue_valid = 1'b1; rs2_addr = 5'd9; #1;
    chk("sc.consumer", XLEN'(issue_stall), 32'h1);
    cyc("sc.cons");
    idle_inputs(); WB_En = 1'b1; WB_Addr = 5'd9; WB_Data = 32'h999;
    cyc("sc.clr");

    // WAW stall on a busy destination
    idle_inputs(); issue_valid = 1'b1; issue_rd = 5'd4;
    cyc("waw.iss");
    #1;
    chk("waw.stall", XLEN'(issue_stall), 32'h1);
    cyc("waw.h1");
    cyc("waw.h2");
    WB_En = 1'b1; WB_Addr = 5'd4; WB_Data = 32'h44;
    cyc("waw.wb");
    idle_inputs(); WB_En = 1'b1; WB_Addr = 5'd4; WB_Data = 32'h45;
    cyc("waw.clr");

    // Randomized traffic, hazards concentrated on low registers
    for (int n = 0; n < 800; n++) begin
      bool_pick: begin
        int wide;
        wide = $urandom_range(0, 3);
        rs1_addr    = (wide == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        rs2_addr    = AW'($urandom_range(0, 7));
        issue_rd    = (wide == 1) ? AW'($urandom) : AW'($urandom_range(0, 7));
        issue_valid = ($urandom_range(0, 1) == 1);
        WB_En       = ($urandom_range(0, 9) < 5);
        WB_Addr     = AW'($urandom_range(0, 7));
        WB_Data     = $urandom;
      end
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
